// File: rtl/dff_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM state encoding
// and the pointer-width helper.
package dff_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Index width for N requesters; never narrower than one bit so N=1 still has a pointer.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_pick.sv
// Combinational round-robin picker: first set request bit found scanning
// cyclically upward from the pointer.
module rr_priority_pick
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand_s;

  // Scan from the farthest candidate back to ptr so the nearest request is written last and wins.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = PW'((int'(ptr_i) + k) % N);
      if (req_i[cand_s]) begin
        pick_o         = '0;
        pick_o[cand_s] = 1'b1;
        idx_o          = cand_s;
        any_o          = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin sequencer that lets N requesters take turns writing one shared
// W-bit register (Q / Q_n): IDLE -> GRANT -> WRITE -> ACK -> IDLE.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] WDATA,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   ACK,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   Q_n,
  output logic           BUSY
);

  localparam int PW = ptr_width(N);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d;
  logic [W-1:0]  hold_q, hold_d, q_q, q_d, qn_q, qn_d;
  logic [N-1:0]  gnt_q, gnt_d, ack_q, ack_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  pick_oh_s, g_oh_s;
  logic [PW-1:0] pick_idx_s, ptr_next_s;
  logic          pick_any_s;
  logic [W-1:0]  slice_s;

  rr_priority_pick #(.N(N), .PW(PW)) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .pick_o(pick_oh_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // Decode the granted index and select its data slice; unselected slices never reach hold.
  always_comb begin
    g_oh_s  = '0;
    slice_s = '0;
    for (int i = 0; i < N; i++) begin
      if (g_q == PW'(i)) begin
        g_oh_s[i] = 1'b1;
        slice_s   = WDATA[i*W +: W];
      end else begin
        g_oh_s[i] = 1'b0;
      end
    end
    ptr_next_s = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);
  end

  // Next-state logic; GNT/ACK/BUSY are computed from the next state so the outputs are flops.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    hold_d  = hold_q;
    q_d     = q_q;
    qn_d    = qn_q;
    gnt_d   = '0;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          g_d     = pick_idx_s;
          gnt_d   = pick_oh_s;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (|(REQ & g_oh_s)) begin
          hold_d  = slice_s;
          gnt_d   = g_oh_s;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        q_d     = hold_q;
        qn_d    = ~hold_q;
        ack_d   = g_oh_s;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ptr_d   = ptr_next_s;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      hold_q  <= '0;
      q_q     <= '0;
      qn_q    <= '1;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign Q    = q_q;
  assign Q_n  = qn_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter (N=4, W=8): directed scenarios plus
// randomized transactions against a transaction-level round-robin model.
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] WDATA;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic [W-1:0]   Q;
  logic [W-1:0]   Q_n;
  logic           BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   ptr_m = 0;

  always #5 CLK = ~CLK;

  dff_reg_arbiter #(.N(N), .W(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .WDATA(WDATA),
    .GNT  (GNT),
    .ACK  (ACK),
    .Q    (Q),
    .Q_n  (Q_n),
    .BUSY (BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin winner: first requesting index scanning ptr, ptr+1, ... mod N.
  function automatic int arb(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr_m + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: every ACK must match the oldest expected write; invariants each cycle.
  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [7:0] nq;
    if (!RST) begin
      nq = ~Q;
      chk("qn_is_not_q", Q_n, nq);
      chk("gnt_onehot", ($countones(GNT) <= 1), 1);
      chk("ack_onehot", ($countones(ACK) <= 1), 1);
      if (ACK != '0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", ACK, 0);
        end else begin
          e  = sb.pop_front();
          nq = ~e.data;
          chk("ack_idx", ACK, 32'(1) << e.idx);
          chk("q_data", Q, e.data);
          chk("qn_data", Q_n, nq);
          chk("gnt_during_ack", GNT, 0);
        end
      end
    end
  end

  // Issue one arbitration from an IDLE negedge; abort drops the winner's REQ after its grant.
  task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] wd, input bit abort);
    int           win;
    int           cyc;
    logic [N-1:0] m;
    logic [W-1:0] q_before;
    exp_t         e;
    chk("idle_before_txn", BUSY, 0);
    win      = arb(r);
    q_before = Q;
    REQ      = r;
    WDATA    = wd;
    if (!abort) begin
      e.idx  = win;
      e.data = wd[win*W +: W];
      sb.push_back(e);
    end
    @(negedge CLK);
    chk("gnt_winner", GNT, 32'(1) << win);
    if (abort) begin
      m      = '0;
      m[win] = 1'b1;
      REQ    = r & ~m;
      @(negedge CLK);
      chk("abort_idle", BUSY, 0);
      chk("abort_q_kept", Q, q_before);
      chk("abort_no_ack", ACK, 0);
    end else begin
      cyc = 1;
      while (BUSY && cyc < 8) begin
        @(negedge CLK);
        cyc++;
      end
      chk("txn_latency", cyc, 4);
      chk("ack_consumed", sb.size(), 0);
      ptr_m = (win + 1) % N;
    end
  endtask

  initial begin
    RST   = 1'b1;
    REQ   = '0;
    WDATA = '0;
    repeat (2) @(negedge CLK);
    chk("rst_q", Q, 8'h00);
    chk("rst_qn", Q_n, 8'hFF);
    chk("rst_gnt", GNT, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Reset while the write is pending: the register must never take 8'h3C.
    REQ   = 4'b0001;
    WDATA = 32'h0000_003C;
    @(negedge CLK);
    chk("wr_rst_gnt_before", GNT, 4'b0001);
    @(negedge CLK);
    #1 RST = 1'b1;
    REQ = '0;
    #1;
    chk("wr_rst_q", Q, 8'h00);
    chk("wr_rst_qn", Q_n, 8'hFF);
    chk("wr_rst_gnt", GNT, 0);
    chk("wr_rst_busy", BUSY, 0);
    @(negedge CLK);
    RST   = 1'b0;
    ptr_m = 0;
    sb.delete();
    repeat (3) @(negedge CLK);
    chk("wr_rst_q_after", Q, 8'h00);

    // Single requester 2 with 8'hA5.
    do_txn(4'b0100, 32'h00A5_0000, 1'b0);

    // Async reset pulse mid-cycle with no clock edge.
    REQ = '0;
    #2 RST = 1'b1;
    #1;
    chk("async_q", Q, 8'h00);
    chk("async_qn", Q_n, 8'hFF);
    chk("async_busy", BUSY, 0);
    #1 RST = 1'b0;
    ptr_m = 0;
    sb.delete();
    @(negedge CLK);

    // All requesting: grants rotate 0,1,2,3,0.
    for (int t = 0; t < 5; t++) do_txn(4'b1111, 32'h1312_1110, 1'b0);

    // Requester 1 alone, withdrawn during GRANT.
    do_txn(4'b0010, 32'h0000_7700, 1'b1);

    // Move ptr to 3, then 4'b1001 grants 3 then wraps to 0.
    do_txn(4'b0100, 32'h0022_0000, 1'b0);
    do_txn(4'b1001, 32'h9900_0088, 1'b0);
    do_txn(4'b1001, 32'h9900_0088, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, (1 << N) - 1));
      do_txn(r, $urandom, ($urandom_range(0, 3) == 0));
    end

    REQ = '0;
    repeat (3) @(negedge CLK);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_idle", BUSY, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
